// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: command codes, FSM states,
// instruction classes and the select-field constants driven on the datapath.
package mc_ctrl_pkg;

    localparam int CMD_NOP  = 0;
    localparam int CMD_ADD  = 1;
    localparam int CMD_SUB  = 2;
    localparam int CMD_ORI  = 3;
    localparam int CMD_LW   = 4;
    localparam int CMD_SW   = 5;
    localparam int CMD_BEQ  = 6;
    localparam int CMD_JAL  = 7;
    localparam int CMD_JR   = 8;
    localparam int CMD_LUI  = 9;
    localparam int CMD_MULT = 10;
    localparam int CMD_DIV  = 11;
    localparam int CMD_MFHI = 12;
    localparam int CMD_MFLO = 13;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4,
        S_MDU_WAIT = 3'd5
    } state_t;

    // Which path through EXEC/MEM/WB an instruction takes.
    typedef enum logic [2:0] {
        CLS_NOP, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JR, CLS_MDU
    } cls_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_MULT = 4'd3;
    localparam logic [3:0] ALU_DIV  = 4'd4;

    localparam logic [3:0] OPT_RT   = 4'd0;
    localparam logic [3:0] OPT_ZEXT = 4'd1;
    localparam logic [3:0] OPT_SEXT = 4'd2;

    localparam logic [3:0] GRF_ALU = 4'd0;
    localparam logic [3:0] GRF_MEM = 4'd1;
    localparam logic [3:0] GRF_PC4 = 4'd2;
    localparam logic [3:0] GRF_LUI = 4'd3;
    localparam logic [3:0] GRF_HI  = 4'd4;
    localparam logic [3:0] GRF_LO  = 4'd5;

    localparam logic [2:0] JMP_PC4    = 3'd0;
    localparam logic [2:0] JMP_BRANCH = 3'd1;
    localparam logic [2:0] JMP_JAL    = 3'd2;
    localparam logic [2:0] JMP_RS     = 3'd3;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [3:0] operand_type;
        logic [3:0] grf_write;
        logic [2:0] jump_signal;
    } sel_t;

    localparam sel_t SEL_NONE = '0;

    function automatic sel_t mk_sel(logic [3:0] alu, logic [3:0] opt,
                                    logic [3:0] grf, logic [2:0] jmp);
        sel_t s;
        s.alu_op       = alu;
        s.operand_type = opt;
        s.grf_write    = grf;
        s.jump_signal  = jmp;
        return s;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational command decoder: datapath selects, instruction class, illegal flag.
// MDU commands 10-13 decode only when MC_CTRL_MDU_EN is defined.
module mc_ctrl_decode import mc_ctrl_pkg::*; #(
    parameter int CMD_W = 5
) (
    input  logic [CMD_W-1:0] command,
    output sel_t             sel,
    output cls_t             cls,
    output logic             illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        sel     = SEL_NONE;
        cls     = CLS_NOP;
        illegal = 1'b0;
        case (int'(command))
            CMD_NOP: ;
            CMD_ADD: begin sel = mk_sel(ALU_ADD, OPT_RT,   GRF_ALU, JMP_PC4);    cls = CLS_ALU;    end
            CMD_SUB: begin sel = mk_sel(ALU_SUB, OPT_RT,   GRF_ALU, JMP_PC4);    cls = CLS_ALU;    end
            CMD_ORI: begin sel = mk_sel(ALU_OR,  OPT_ZEXT, GRF_ALU, JMP_PC4);    cls = CLS_ALU;    end
            CMD_LW:  begin sel = mk_sel(ALU_ADD, OPT_SEXT, GRF_MEM, JMP_PC4);    cls = CLS_LOAD;   end
            CMD_SW:  begin sel = mk_sel(ALU_ADD, OPT_SEXT, GRF_ALU, JMP_PC4);    cls = CLS_STORE;  end
            CMD_BEQ: begin sel = mk_sel(ALU_SUB, OPT_RT,   GRF_ALU, JMP_BRANCH); cls = CLS_BRANCH; end
            CMD_JAL: begin sel = mk_sel(ALU_ADD, OPT_RT,   GRF_PC4, JMP_JAL);    cls = CLS_JAL;    end
            CMD_JR:  begin sel = mk_sel(ALU_ADD, OPT_RT,   GRF_ALU, JMP_RS);     cls = CLS_JR;     end
            CMD_LUI: begin sel = mk_sel(ALU_ADD, OPT_ZEXT, GRF_LUI, JMP_PC4);    cls = CLS_ALU;    end
`ifdef MC_CTRL_MDU_EN
            CMD_MULT: begin sel = mk_sel(ALU_MULT, OPT_RT, GRF_ALU, JMP_PC4);    cls = CLS_MDU;    end
            CMD_DIV:  begin sel = mk_sel(ALU_DIV,  OPT_RT, GRF_ALU, JMP_PC4);    cls = CLS_MDU;    end
            CMD_MFHI: begin sel = mk_sel(ALU_ADD,  OPT_RT, GRF_HI,  JMP_PC4);    cls = CLS_ALU;    end
            CMD_MFLO: begin sel = mk_sel(ALU_ADD,  OPT_RT, GRF_LO,  JMP_PC4);    cls = CLS_ALU;    end
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle processor control FSM (FETCH/DECODE/EXEC/MEM/WB/MDU_WAIT).
// Define MC_CTRL_MDU_EN to build the mult/div unit wait state and busy output.
module mc_ctrl import mc_ctrl_pkg::*; #(
    parameter int CMD_W   = 5,
    parameter int MDU_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CMD_W-1:0] command,
    input  logic             zero,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_write,
    output logic [3:0]       ALUop,
    output logic [3:0]       operand_type,
    output logic [3:0]       GRF_write,
    output logic [2:0]       jump_signal,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic             busy,
    output logic             illegal
);

    state_t           state_q, state_d;
    sel_t             sel_q, sel_dec, sel_c;
    cls_t             cls_q, cls_dec;
    logic             ill_dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pc_c, ir_c, reg_c, mem_c, done_c, ill_c;
`ifdef MC_CTRL_MDU_EN
    logic             busy_c;
`endif

    mc_ctrl_decode #(.CMD_W(CMD_W)) u_decode (
        .command (command),
        .sel     (sel_dec),
        .cls     (cls_dec),
        .illegal (ill_dec)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments only.
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            sel_q   <= SEL_NONE;
            cls_q   <= CLS_NOP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_DECODE) begin
                sel_q <= sel_dec;
                cls_q <= cls_dec;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_c   = sel_q;
        pc_c    = 1'b0;
        ir_c    = 1'b0;
        reg_c   = 1'b0;
        mem_c   = 1'b0;
        done_c  = 1'b0;
        ill_c   = 1'b0;
`ifdef MC_CTRL_MDU_EN
        busy_c  = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                sel_c   = SEL_NONE;
                ir_c    = 1'b1;
                pc_c    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                sel_c = sel_dec;
                ill_c = ill_dec;
                case (cls_dec)
                    CLS_NOP: begin state_d = S_FETCH; done_c = 1'b1; end
                    CLS_JAL: state_d = S_WB;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                // Loaded on every EXEC; only MDU_WAIT ever reads it.
                cnt_d = CNT_W'(MDU_LAT - 1);
                case (cls_q)
                    CLS_ALU:             state_d = S_WB;
                    CLS_LOAD, CLS_STORE: state_d = S_MEM;
                    CLS_BRANCH: begin pc_c = zero; state_d = S_FETCH; done_c = 1'b1; end
                    CLS_JR:     begin pc_c = 1'b1; state_d = S_FETCH; done_c = 1'b1; end
`ifdef MC_CTRL_MDU_EN
                    CLS_MDU:             state_d = S_MDU_WAIT;
`endif
                    default: begin state_d = S_FETCH; done_c = 1'b1; end
                endcase
            end
            S_MEM: begin
                if (cls_q == CLS_LOAD) begin
                    state_d = S_WB;
                end else begin
                    mem_c   = 1'b1;
                    state_d = S_FETCH;
                    done_c  = 1'b1;
                end
            end
            S_WB: begin
                reg_c   = 1'b1;
                pc_c    = (cls_q == CLS_JAL);
                state_d = S_FETCH;
                done_c  = 1'b1;
            end
            S_MDU_WAIT: begin
`ifdef MC_CTRL_MDU_EN
                busy_c = 1'b1;
`endif
                if (cnt_q == '0) begin
                    state_d = S_FETCH;
                    done_c  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                sel_c   = SEL_NONE;
                state_d = S_FETCH;
            end
        endcase
    end

    // A reset cycle forces every output to zero, including mid-instruction strobes.
    assign pc_write     = pc_c   & ~reset;
    assign ir_write     = ir_c   & ~reset;
    assign reg_write    = reg_c  & ~reset;
    assign mem_write    = mem_c  & ~reset;
    assign instr_done   = done_c & ~reset;
    assign illegal      = ill_c  & ~reset;
    assign ALUop        = reset ? 4'd0 : sel_c.alu_op;
    assign operand_type = reset ? 4'd0 : sel_c.operand_type;
    assign GRF_write    = reset ? 4'd0 : sel_c.grf_write;
    assign jump_signal  = reset ? 3'd0 : sel_c.jump_signal;
    assign state        = reset ? 3'd0 : state_q;
`ifdef MC_CTRL_MDU_EN
    assign busy         = busy_c & ~reset;
`else
    assign busy         = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected cycle records from a
// behavioural model, compared on every falling edge, plus literal pulse counts.
module tb_mc_ctrl;

    localparam int CMD_W   = 5;
    localparam int MDU_LAT = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [CMD_W-1:0] command = '0;
    logic             zero = 1'b0;
    logic             pc_write, ir_write, reg_write, mem_write;
    logic [3:0]       ALUop, operand_type, GRF_write;
    logic [2:0]       jump_signal, state;
    logic             instr_done, busy, illegal;

    mc_ctrl #(.CMD_W(CMD_W), .MDU_LAT(MDU_LAT)) dut (
        .clk(clk), .reset(reset), .command(command), .zero(zero),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_write(mem_write), .ALUop(ALUop), .operand_type(operand_type),
        .GRF_write(GRF_write), .jump_signal(jump_signal), .state(state),
        .instr_done(instr_done), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pc, ir, rw, mw;
        logic [3:0] alu, opt, grf;
        logic [2:0] jmp;
        logic       done, busy, ill;
    } exp_t;

    typedef struct packed {
        logic [3:0] alu, opt, grf;
        logic [2:0] jmp;
    } bsel_t;

    typedef int iq_t[$];

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_rw = 0, n_mw = 0, n_pc = 0, n_busy = 0, n_ill = 0, n_done = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit is_legal(int c);
        if (c >= 0 && c <= 9) return 1'b1;
`ifdef MC_CTRL_MDU_EN
        if (c >= 10 && c <= 13) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Datapath selects each command needs, straight from the ISA meaning.
    function automatic bsel_t sel_for(int c);
        bsel_t s = '0;
        case (c)
            2:  s.alu = 4'd1;
            3:  begin s.alu = 4'd2; s.opt = 4'd1; end
            4:  begin s.opt = 4'd2; s.grf = 4'd1; end
            5:  s.opt = 4'd2;
            6:  begin s.alu = 4'd1; s.jmp = 3'd1; end
            7:  begin s.grf = 4'd2; s.jmp = 3'd2; end
            8:  s.jmp = 3'd3;
            9:  begin s.opt = 4'd1; s.grf = 4'd3; end
            10: s.alu = 4'd3;
            11: s.alu = 4'd4;
            12: s.grf = 4'd4;
            13: s.grf = 4'd5;
            default: s = '0;
        endcase
        if (!is_legal(c)) s = '0;
        return s;
    endfunction

    // State visited on each cycle of an instruction, FETCH included.
    task automatic state_seq(input int c, output iq_t seq);
        seq = {};
        if (!is_legal(c) || c == 0) seq = '{0, 1};
        else case (c)
            4:       seq = '{0, 1, 2, 3, 4};
            5:       seq = '{0, 1, 2, 3};
            6, 8:    seq = '{0, 1, 2};
            7:       seq = '{0, 1, 4};
            10, 11:  begin seq = '{0, 1, 2}; repeat (MDU_LAT) seq.push_back(5); end
            default: seq = '{0, 1, 2, 4};
        endcase
    endtask

    task automatic push_instr(input int c, input bit z, input int max, output int n);
        iq_t   seq;
        bsel_t s;
        exp_t  e;
        int    st;
        state_seq(c, seq);
        s = sel_for(c);
        n = (max < seq.size()) ? max : seq.size();
        for (int i = 0; i < n; i++) begin
            st     = seq[i];
            e      = '0;
            e.st   = 3'(st);
            e.ir   = (st == 0);
            e.pc   = (st == 0) || (c == 6 && st == 2 && z) || (c == 8 && st == 2) || (c == 7 && st == 4);
            e.rw   = (st == 4);
            e.mw   = (c == 5 && st == 3);
            e.busy = (st == 5);
            e.ill  = !is_legal(c) && st == 1;
            e.done = (i == seq.size() - 1);
            if (st != 0) begin
                e.alu = s.alu; e.opt = s.opt; e.grf = s.grf; e.jmp = s.jmp;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic push_zero();
        exp_t e = '0;
        exp_q.push_back(e);
    endtask

    // Called just after the edge that starts FETCH; returns just after the next one.
    task automatic run_instr(input int c, input bit z);
        int n;
        command = CMD_W'(c);
        zero    = z;
        push_instr(c, z, 1000, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state",        32'(state),        32'(e.st));
            check("pc_write",     32'(pc_write),     32'(e.pc));
            check("ir_write",     32'(ir_write),     32'(e.ir));
            check("reg_write",    32'(reg_write),    32'(e.rw));
            check("mem_write",    32'(mem_write),    32'(e.mw));
            check("ALUop",        32'(ALUop),        32'(e.alu));
            check("operand_type", 32'(operand_type), 32'(e.opt));
            check("GRF_write",    32'(GRF_write),    32'(e.grf));
            check("jump_signal",  32'(jump_signal),  32'(e.jmp));
            check("instr_done",   32'(instr_done),   32'(e.done));
            check("busy",         32'(busy),         32'(e.busy));
            check("illegal",      32'(illegal),      32'(e.ill));
        end
    end

    always @(negedge clk) begin
        if (reg_write)  n_rw++;
        if (mem_write)  n_mw++;
        if (pc_write)   n_pc++;
        if (busy)       n_busy++;
        if (illegal)    n_ill++;
        if (instr_done) n_done++;
    end

    initial begin
        iq_t   s;
        bsel_t sl;
        int    b0, b1, n;

        // Pin the model against hand-derived latencies and selects.
        state_seq(0, s);  check("model nop len", 32'(s.size()), 32'd2);
        state_seq(1, s);  check("model add len", 32'(s.size()), 32'd4);
        state_seq(4, s);  check("model lw len",  32'(s.size()), 32'd5);
        state_seq(6, s);  check("model beq len", 32'(s.size()), 32'd3);
        state_seq(15, s); check("model illegal len", 32'(s.size()), 32'd2);
`ifdef MC_CTRL_MDU_EN
        state_seq(10, s); check("model mult len", 32'(s.size()), 32'd8);
`endif
        sl = sel_for(4);  check("model lw sel", 32'(sl), 32'({4'd0, 4'd2, 4'd1, 3'd0}));
        sl = sel_for(7);  check("model jal sel", 32'(sl), 32'({4'd0, 4'd0, 4'd2, 3'd2}));

        push_zero();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        b0 = n_rw; b1 = n_done;
        run_instr(1, 1'b0);
        check("add reg_write pulses", 32'(n_rw - b0), 32'd1);
        check("add instr_done pulses", 32'(n_done - b1), 32'd1);
        run_instr(2, 1'b0);
        run_instr(3, 1'b0);
        b0 = n_rw;
        run_instr(4, 1'b0);
        check("lw reg_write pulses", 32'(n_rw - b0), 32'd1);
        b0 = n_mw;
        run_instr(5, 1'b0);
        check("sw mem_write pulses", 32'(n_mw - b0), 32'd1);
        b0 = n_pc;
        run_instr(6, 1'b1);
        check("beq taken pc pulses", 32'(n_pc - b0), 32'd2);
        b0 = n_pc; b1 = n_done;
        run_instr(6, 1'b0);
        check("beq untaken pc pulses", 32'(n_pc - b0), 32'd1);
        check("beq untaken done", 32'(n_done - b1), 32'd1);
        run_instr(7, 1'b0);
        run_instr(8, 1'b0);
        run_instr(9, 1'b0);
        run_instr(0, 1'b0);
        b0 = n_ill;
        run_instr(15, 1'b0);
        check("cmd 15 illegal pulses", 32'(n_ill - b0), 32'd1);
        run_instr(31, 1'b0);
        b0 = n_busy; b1 = n_ill;
        run_instr(10, 1'b0);
`ifdef MC_CTRL_MDU_EN
        check("mult busy cycles", 32'(n_busy - b0), 32'd5);
`else
        check("mult busy cycles", 32'(n_busy - b0), 32'd0);
        check("mult illegal pulses", 32'(n_ill - b1), 32'd1);
`endif
        run_instr(11, 1'b0);
        run_instr(12, 1'b0);
        run_instr(13, 1'b0);

        // Reset landing on the MEM cycle of sw must swallow the store.
        b0 = n_mw;
        command = CMD_W'(5);
        zero    = 1'b0;
        push_instr(5, 1'b0, 3, n);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
        push_zero();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("sw mem_write under reset", 32'(n_mw - b0), 32'd0);
        check("state after reset", 32'(state), 32'd0);
        run_instr(1, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        check("expected queue drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
